// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target register block and the init sequencer.
// Holds the protocol state encoding, R/W and ACK bit meanings, the default
// 7-bit device address and a pointer-increment helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_ADDR,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h39;

  // Register pointer advances modulo 256.
  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge and bus-condition detection.
//   clk_ref, reset      : system clock, async active-high reset
//   scl_in, sda_in      : raw pad levels
//   scl_rise, scl_fall  : one-cycle pulses on synchronized SCL edges
//   start_det, stop_det : SDA fall / rise while synchronized SCL is high
//   sda_s               : synchronized SDA level
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_ref,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
  end

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is not mistaken for a bus condition.
  assign start_det = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
  assign stop_det  = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an external register file.
//   clk_ref, reset    : system clock, async active-high reset
//   scl_in, sda_in    : pad levels; sda_oe pulls SDA low when 1
//   wr_en/addr/data   : one-cycle register write strobe
//   rd_addr, rd_data  : register pointer and combinational read-back
//   busy              : START .. STOP
//   addr_match        : addressed (after address ACK until STOP/START)
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = I2C_DEV_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_ref,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       addr_match
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk_ref   (clk_ref),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;
  logic       match_q, match_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    match_d   = match_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      match_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      match_d   = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
        end
        ST_RD_ACK: begin
          // Pointer advances on ACK and NACK alike; NACK ends the read here.
          ptr_d = ptr_inc(ptr_q);
          if (sda_s == I2C_NACK) state_d = ST_IGNORE;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ST_ACK_ADDR;
              sda_oe_d = 1'b1;
              match_d  = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ACK_ADDR: begin
          bit_cnt_d = '0;
          if (rw_q == I2C_RW_WRITE) begin
            state_d  = ST_REG_ADDR;
            sda_oe_d = 1'b0;
          end else begin
            state_d  = ST_RD_DATA;
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end
        end
        ST_REG_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            ptr_d     = shift_q;
            sda_oe_d  = 1'b1;
            state_d   = ST_ACK_REG;
            bit_cnt_d = '0;
          end
        end
        ST_ACK_REG, ST_ACK_WR: begin
          sda_oe_d  = 1'b0;
          state_d   = ST_WR_DATA;
          bit_cnt_d = '0;
        end
        ST_WR_DATA: begin
          if (bit_cnt_q == 4'd8) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_inc(ptr_q);
            sda_oe_d  = 1'b1;
            state_d   = ST_ACK_WR;
            bit_cnt_d = '0;
          end
        end
        ST_RD_DATA: begin
          // The MSB went out on entry; each later fall presents the next bit.
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            state_d   = ST_RD_ACK;
            bit_cnt_d = '0;
          end else begin
            sda_oe_d = ~shift_q[6];
            shift_d  = {shift_q[6:0], 1'b0};
          end
        end
        ST_RD_ACK: begin
          // Only reached after a master ACK; rd_data reflects the new pointer.
          state_d   = ST_RD_DATA;
          shift_d   = rd_data;
          sda_oe_d  = ~rd_data[7];
          bit_cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= I2C_RW_WRITE;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      match_q   <= match_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = ptr_q;
  assign busy       = busy_q;
  assign addr_match = match_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: acts as bus master, keeps a transaction-level
// model (pointer, register image, queue of expected writes) and checks the
// DUT against it, plus literal expectations for the directed scenarios.
module tb_i2c_target_regs;

  localparam int Q = 4;  // clk_ref cycles per quarter SCL period

  logic       clk_ref = 1'b0;
  logic       reset   = 1'b1;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_en, busy, addr_match;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] regfile [256];

  always #10 clk_ref = ~clk_ref;

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;  // open-drain wired-AND with pull-up
  assign rd_data = regfile[rd_addr];

  i2c_target_regs #(.DEV_ADDR(7'h39), .SYNC_STAGES(2)) dut (
    .clk_ref    (clk_ref),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .addr_match (addr_match)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // External register storage owned by the bench.
  always @(posedge clk_ref) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regfile[i] <= init_val(i);
    end else if (wr_en) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          mdl_ptr = 0;
  logic [7:0]  mdl_mem [256];
  logic [15:0] exp_wr [$];
  bit          drive_ok = 1'b0;
  bit          idle_chk = 1'b0;
  int          wr_cnt = 0;
  int          oe_cnt = 0;
  logic [7:0]  last_wa = '0;
  logic [7:0]  last_wd = '0;
  logic [7:0]  txd [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk_ref) begin : compare
    logic [15:0] e;
    if (!reset) begin
      if (sda_oe) oe_cnt++;
      if (wr_en) begin
        wr_cnt++;
        last_wa = wr_addr;
        last_wd = wr_data;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got wr_en addr 0x%0h data 0x%0h, required none", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_pair", {wr_addr, wr_data}, e);
        end
      end
      if (scl_m && !drive_ok) chk("sda_oe_slot", sda_oe, 0);
      if (idle_chk) begin
        chk("idle_ptr", rd_addr, mdl_ptr);
        chk("idle_busy", busy, 0);
        chk("idle_match", addr_match, 0);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic qwait;
    repeat (Q) @(negedge clk_ref);
  endtask

  task automatic mdl_reset;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
    mdl_ptr = 0;
    exp_wr.delete();
  endtask

  task automatic i2c_start;
    idle_chk = 1'b0;
    drive_ok = 1'b0;
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b0; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic i2c_stop;
    drive_ok = 1'b0;
    sda_m = 1'b0; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b1; qwait;
    qwait;
    idle_chk = 1'b1;
  endtask

  task automatic put_bit(input logic b);
    drive_ok = 1'b0;
    sda_m = b; qwait;
    scl_m = 1'b1; qwait; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic get_bit(input bit may_drive, output logic b);
    drive_ok = may_drive;
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    b = sda_in;
    qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(exp_ack, a);
    chk(name, a, exp_ack ? 0 : 1);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      get_bit(1'b1, v);
      b[i] = v;
    end
    put_bit(nack);
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] reg_a, input int n);
    bit m;
    m = (dev == 7'h39);
    i2c_start;
    send_byte({dev, 1'b0}, m, "ack_dev_w");
    chk("match_after_dev_w", addr_match, m);
    chk("busy_in_txn", busy, 1);
    if (m) mdl_ptr = reg_a;
    send_byte(reg_a, m, "ack_reg");
    for (int i = 0; i < n; i++) begin
      if (m) begin
        exp_wr.push_back({8'(mdl_ptr), txd[i]});
        mdl_mem[mdl_ptr] = txd[i];
        mdl_ptr = (mdl_ptr + 1) % 256;
      end
      send_byte(txd[i], m, "ack_wdata");
    end
    i2c_stop;
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] reg_a, input int n,
                         output logic [7:0] last);
    logic [7:0] got, expv;
    last = '0;
    i2c_start;
    if (set_ptr) begin
      send_byte(8'h72, 1'b1, "ack_dev_rw");
      mdl_ptr = reg_a;
      send_byte(reg_a, 1'b1, "ack_reg_r");
      i2c_start;
    end
    send_byte(8'h73, 1'b1, "ack_dev_r");
    chk("match_after_dev_r", addr_match, 1);
    for (int i = 0; i < n; i++) begin
      expv = mdl_mem[mdl_ptr];
      recv_byte(got, (i == n - 1));
      chk("rd_byte", got, expv);
      mdl_ptr = (mdl_ptr + 1) % 256;
      last = got;
    end
    i2c_stop;
  endtask

  initial begin : main
    int         c0, o0, kind, n;
    logic [7:0] got, r;
    logic [6:0] d;
    logic [7:0] pb;

    mdl_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk_ref);
    reset = 1'b0;
    repeat (2) @(negedge clk_ref);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_match", addr_match, 0);
    idle_chk = 1'b1;
    qwait;

    // Single write 0x72,0x41,0x10
    c0 = wr_cnt;
    txd[0] = 8'h10;
    do_write(7'h39, 8'h41, 1);
    chk("t1_wr_count", wr_cnt - c0, 1);
    chk("t1_wr_addr", last_wa, 8'h41);
    chk("t1_wr_data", last_wd, 8'h10);
    chk("t1_ptr", rd_addr, 8'h42);
    chk("t1_busy", busy, 0);

    // Burst wrapping the pointer
    c0 = wr_cnt;
    txd[0] = 8'hAA; txd[1] = 8'hBB; txd[2] = 8'hCC;
    do_write(7'h39, 8'hFE, 3);
    chk("t2_wr_count", wr_cnt - c0, 3);
    chk("t2_last_addr", last_wa, 8'h00);
    chk("t2_last_data", last_wd, 8'hCC);
    chk("t2_ptr", rd_addr, 8'h01);

    // Address mismatch (0x74)
    c0 = wr_cnt;
    o0 = oe_cnt;
    txd[0] = 8'h10;
    do_write(7'h3A, 8'h41, 1);
    chk("t3_wr_count", wr_cnt - c0, 0);
    chk("t3_oe_cycles", oe_cnt - o0, 0);
    chk("t3_ptr", rd_addr, 8'h01);
    chk("t3_busy", busy, 0);

    // Read 0xA5 back from 0x05 via repeated START, master NACK
    txd[0] = 8'hA5;
    do_write(7'h39, 8'h05, 1);
    do_read(1'b1, 8'h05, 1, got);
    chk("t4_rd_byte", got, 8'hA5);
    chk("t4_sda_oe", sda_oe, 0);
    chk("t4_ptr", rd_addr, 8'h06);

    // STOP after 5 data bits
    c0 = wr_cnt;
    i2c_start;
    send_byte(8'h72, 1'b1, "t5_ack_dev");
    mdl_ptr = 8'h41;
    send_byte(8'h41, 1'b1, "t5_ack_reg");
    pb = 8'h9C;
    for (int i = 7; i >= 3; i--) put_bit(pb[i]);
    i2c_stop;
    chk("t5_wr_count", wr_cnt - c0, 0);
    chk("t5_ptr", rd_addr, 8'h41);
    chk("t5_busy", busy, 0);

    // Reset while the address ACK is being driven
    i2c_start;
    pb = 8'h72;
    for (int i = 7; i >= 0; i--) put_bit(pb[i]);
    drive_ok = 1'b1;
    for (int i = 0; i < 32 && !sda_oe; i++) @(negedge clk_ref);
    chk("t6_ack_driven", sda_oe, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_sda_oe", sda_oe, 0);
    chk("t6_rst_ptr", rd_addr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_match", addr_match, 0);
    chk("t6_rst_wr_en", wr_en, 0);
    mdl_reset;
    drive_ok = 1'b0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (3) @(negedge clk_ref);
    reset = 1'b0;
    qwait;
    idle_chk = 1'b1;
    txd[0] = 8'h5A;
    do_write(7'h39, 8'h22, 1);
    chk("t6_after_ptr", rd_addr, 8'h23);

    // Randomized transactions against the model
    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 3));
      r = 8'($urandom);
      if (kind <= 1) begin
        d = 7'h39;
        if ($urandom_range(0, 5) == 0) begin
          d = 7'($urandom);
          if (d == 7'h39) d = 7'h3A;
        end
        n = int'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
        do_write(d, r, n);
      end else begin
        n = int'($urandom_range(1, 3));
        do_read(kind == 2, r, n, got);
      end
      chk("rnd_ptr", rd_addr, mdl_ptr);
    end

    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
